// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and widths for the instruction fetch stage
package fetch_unit_pkg;

    localparam int PC_W_DEF    = 10;
    localparam int INSTR_W_DEF = 16;
    localparam int WAIT_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - program memory read bus between fetch unit and memory
interface fetch_unit_if
    import fetch_unit_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
);

    logic               mem_rd;
    logic [PC_W-1:0]    mem_addr;
    logic [INSTR_W-1:0] mem_rdata;
    logic               mem_ack;

    modport master (
        output mem_rd,
        output mem_addr,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_rd,
        input  mem_addr,
        output mem_rdata,
        output mem_ack
    );

endinterface

// File: rtl/fetch_timer.sv
// rtl/fetch_timer.sv - wait counter that flags when a memory read has waited too long
module fetch_timer
    import fetch_unit_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam logic [WAIT_W-1:0] LAST = WAIT_W'(TIMEOUT - 1);

    logic [WAIT_W-1:0] cnt;

    // hit is raised in the cycle whose increment would bring the count to TIMEOUT
    assign hit = en && (cnt == LAST);

    // count unacknowledged read cycles; restart after a clear or an expiry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || hit) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + WAIT_W'(1);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter and single-word instruction fetch with branch redirect
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          PC_W     = PC_W_DEF,
    parameter int          INSTR_W  = INSTR_W_DEF,
    parameter int unsigned RESET_PC = 0,
    parameter int          TIMEOUT  = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_req,
    input  logic               br_taken,
    input  logic [PC_W-1:0]    br_addr,
    fetch_unit_if.master       mem,
    output logic [INSTR_W-1:0] ir_data,
    output logic               ir_w,
    output logic               fetch_done,
    output logic               fetch_err,
    output logic [PC_W-1:0]    pc
);

    localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC);

    fetch_state_t    state;
    logic            rd_q;
    logic [PC_W-1:0] addr_q;
    logic            pend;
    logic [PC_W-1:0] pend_addr;
    logic            in_read;
    logic            tmr_en;
    logic            tmr_clr;
    logic            tmr_hit;

    assign mem.mem_rd   = rd_q;
    assign mem.mem_addr = addr_q;

    assign in_read = (state == ST_READ);
    assign tmr_en  = in_read && !mem.mem_ack;
    assign tmr_clr = !in_read || mem.mem_ack;

    fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (tmr_clr),
        .en  (tmr_en),
        .hit (tmr_hit)
    );

    // fetch sequencer: IDLE -> READ -> WRITE -> IDLE, branches kept pending while busy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            pc         <= PC_RST;
            addr_q     <= PC_RST;
            rd_q       <= 1'b0;
            ir_data    <= '0;
            ir_w       <= 1'b0;
            fetch_done <= 1'b0;
            fetch_err  <= 1'b0;
            pend       <= 1'b0;
            pend_addr  <= '0;
        end else begin
            ir_w       <= 1'b0;
            fetch_done <= 1'b0;
            fetch_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (br_taken) begin
                        pc <= br_addr;
                    end
                    if (fetch_req) begin
                        // a simultaneous branch supplies the address of this fetch
                        addr_q <= br_taken ? br_addr : pc;
                        rd_q   <= 1'b1;
                        state  <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (br_taken) begin
                        pend      <= 1'b1;
                        pend_addr <= br_addr;
                    end
                    if (mem.mem_ack) begin
                        ir_data    <= mem.mem_rdata;
                        rd_q       <= 1'b0;
                        ir_w       <= 1'b1;
                        fetch_done <= 1'b1;
                        state      <= ST_WRITE;
                    end else if (tmr_hit) begin
                        // abandoned fetch: pc only moves if a branch arrived meanwhile
                        rd_q      <= 1'b0;
                        fetch_err <= 1'b1;
                        state     <= ST_IDLE;
                        pend      <= 1'b0;
                        if (br_taken) begin
                            pc <= br_addr;
                        end else if (pend) begin
                            pc <= pend_addr;
                        end
                    end
                end
                ST_WRITE: begin
                    pend  <= 1'b0;
                    state <= ST_IDLE;
                    if (br_taken) begin
                        pc <= br_addr;
                    end else if (pend) begin
                        pc <= pend_addr;
                    end else begin
                        pc <= pc + PC_W'(1);
                    end
                end
                default: begin
                    rd_q  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized checks of fetch_unit against a transaction model
module tb_fetch_unit;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 16;
    localparam int TIMEOUT = 15;

    logic               clk = 1'b0;
    logic               rst;
    logic               fetch_req;
    logic               br_taken;
    logic [PC_W-1:0]    br_addr;
    logic [INSTR_W-1:0] ir_data;
    logic               ir_w;
    logic               fetch_done;
    logic               fetch_err;
    logic [PC_W-1:0]    pc;

    fetch_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) mem_bus ();

    fetch_unit #(
        .PC_W     (PC_W),
        .INSTR_W  (INSTR_W),
        .RESET_PC (0),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_req  (fetch_req),
        .br_taken   (br_taken),
        .br_addr    (br_addr),
        .mem        (mem_bus.master),
        .ir_data    (ir_data),
        .ir_w       (ir_w),
        .fetch_done (fetch_done),
        .fetch_err  (fetch_err),
        .pc         (pc)
    );

    always #5 clk = ~clk;

    logic [INSTR_W-1:0] mem_arr [1024];
    int ack_lat = 0;
    int rd_wait = 0;

    // memory model: acks after ack_lat unacknowledged cycles, garbage data otherwise
    always @(negedge clk) begin
        if (mem_bus.mem_rd === 1'b1) begin
            if (rd_wait == ack_lat) begin
                mem_bus.mem_ack   = 1'b1;
                mem_bus.mem_rdata = mem_arr[mem_bus.mem_addr];
            end else begin
                mem_bus.mem_ack   = 1'b0;
                mem_bus.mem_rdata = INSTR_W'($urandom);
            end
            rd_wait++;
        end else begin
            mem_bus.mem_ack   = 1'b0;
            mem_bus.mem_rdata = INSTR_W'($urandom);
            rd_wait = 0;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int nf       = 0;
    int model_pc = 0;
    logic [INSTR_W-1:0] model_ir = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pc"}, 32'(pc), 0);
        chk({tag, "_addr"}, 32'(mem_bus.mem_addr), 0);
        chk({tag, "_rd"}, 32'(mem_bus.mem_rd), 0);
        chk({tag, "_ir"}, 32'(ir_data), 0);
        chk({tag, "_irw"}, 32'(ir_w), 0);
        chk({tag, "_done"}, 32'(fetch_done), 0);
        chk({tag, "_err"}, 32'(fetch_err), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_pc = 0;
        model_ir = '0;
        chk_reset_outputs("reset");
    endtask

    task automatic idle_branch(input logic [PC_W-1:0] ba);
        br_taken = 1'b1;
        br_addr  = ba;
        @(posedge clk); #1;
        br_taken = 1'b0;
        model_pc = int'(ba);
        chk("idle_br_pc", 32'(pc), 32'(ba));
        chk("idle_br_rd", 32'(mem_bus.mem_rd), 0);
    endtask

    // one fetch starting at the current sample point; c1/c2 inject busy-time branches (0 = none)
    task automatic do_fetch(input bit with_br, input logic [PC_W-1:0] ba, input int lat,
                            input bit hold, input int c1, input logic [PC_W-1:0] a1,
                            input int c2, input logic [PC_W-1:0] a2);
        int a, end_c, tgt, exp_pc, w_cnt, w_cyc, e_cnt, e_cyc, dmis, amov;
        bit tv, tmo;
        logic [INSTR_W-1:0] w_data, exp_ir;
        string p;
        nf++;
        p = $sformatf("f%0d", nf);
        tmo = (lat >= TIMEOUT);
        a = with_br ? int'(ba) : model_pc;
        ack_lat = tmo ? TIMEOUT : lat;
        end_c = tmo ? TIMEOUT + 1 : lat + 3;
        tv = (c1 > 0);
        tgt = (c2 > 0) ? int'(a2) : int'(a1);
        w_cnt = 0; w_cyc = 0; e_cnt = 0; e_cyc = 0; dmis = 0; amov = 0; w_data = '0;
        fetch_req = 1'b1;
        br_taken  = with_br;
        br_addr   = ba;
        for (int c = 1; c <= end_c; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                chk({p, "_rd"}, 32'(mem_bus.mem_rd), 1);
                chk({p, "_pc_busy"}, 32'(pc), 32'(a));
            end
            if (mem_bus.mem_addr !== PC_W'(a)) amov++;
            if (ir_w === 1'b1) begin
                w_cnt++;
                w_cyc = c;
                w_data = ir_data;
            end
            if (fetch_err === 1'b1) begin
                e_cnt++;
                e_cyc = c;
            end
            if (fetch_done !== ir_w) dmis++;
            fetch_req = hold && (c < end_c);
            br_taken  = (c == c1) || (c == c2);
            br_addr   = (c == c2) ? a2 : a1;
        end
        if (tmo) begin
            exp_pc = tv ? tgt : a;
            exp_ir = model_ir;
            chk({p, "_irw_cnt"}, 32'(w_cnt), 0);
            chk({p, "_err_cnt"}, 32'(e_cnt), 1);
            chk({p, "_err_cyc"}, 32'(e_cyc), 32'(TIMEOUT + 1));
        end else begin
            exp_pc = tv ? tgt : (a + 1) % 1024;
            exp_ir = mem_arr[a];
            chk({p, "_irw_cnt"}, 32'(w_cnt), 1);
            chk({p, "_irw_cyc"}, 32'(w_cyc), 32'(lat + 2));
            chk({p, "_irw_data"}, 32'(w_data), 32'(exp_ir));
            chk({p, "_err_cnt"}, 32'(e_cnt), 0);
        end
        chk({p, "_addr"}, 32'(amov), 0);
        chk({p, "_done"}, 32'(dmis), 0);
        chk({p, "_pc"}, 32'(pc), 32'(exp_pc));
        chk({p, "_ir"}, 32'(ir_data), 32'(exp_ir));
        chk({p, "_rd_end"}, 32'(mem_bus.mem_rd), 0);
        model_pc = exp_pc;
        model_ir = exp_ir;
    endtask

    initial begin
        int lat, lastc, c1, c2, irw_seen;
        bit wb;
        rst       = 1'b1;
        fetch_req = 1'b0;
        br_taken  = 1'b0;
        br_addr   = '0;
        for (int i = 0; i < 1024; i++) mem_arr[i] = INSTR_W'($urandom);
        @(posedge clk); #1;
        do_reset();

        // single fetch with ack in the first READ cycle
        mem_arr[0] = 16'h1234;
        do_fetch(0, '0, 0, 0, 0, '0, 0, '0);
        chk("first_pc", 32'(pc), 1);

        // four back-to-back fetches with two wait cycles each
        do_reset();
        for (int i = 0; i < 4; i++) mem_arr[i] = INSTR_W'(i + 1);
        for (int i = 0; i < 4; i++) do_fetch(0, '0, 2, 0, 0, '0, 0, '0);
        chk("b2b_pc", 32'(pc), 4);

        // branch to the last word, then fetch across the wrap
        idle_branch(10'h3FF);
        do_fetch(0, '0, 1, 0, 0, '0, 0, '0);
        do_fetch(0, '0, 0, 0, 0, '0, 0, '0);
        chk("wrap_pc", 32'(pc), 1);

        // branch together with the request, then a branch while reading
        do_fetch(1, 10'h080, 1, 0, 0, '0, 0, '0);
        chk("br_req_pc", 32'(pc), 32'h081);
        do_fetch(0, '0, 2, 0, 2, 10'h200, 0, '0);
        chk("br_read_pc", 32'(pc), 32'h200);

        // two branches while busy with fetch_req held high: the later target wins
        do_fetch(0, '0, 3, 1, 1, 10'h111, 5, 10'h222);

        // timeout, a successful retry, the last-chance ack, and a timeout with pending branch
        do_fetch(0, '0, TIMEOUT, 1, 0, '0, 0, '0);
        do_fetch(0, '0, 0, 0, 0, '0, 0, '0);
        do_fetch(0, '0, TIMEOUT - 1, 0, 0, '0, 0, '0);
        do_fetch(0, '0, TIMEOUT, 0, 7, 10'h155, 0, '0);

        // reset in the middle of a read
        ack_lat   = 5;
        fetch_req = 1'b1;
        @(posedge clk); #1;
        fetch_req = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst_read");
        irw_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (ir_w !== 1'b0) irw_seen++;
        end
        rst = 1'b0;
        chk("rst_read_irw", 32'(irw_seen), 0);
        model_pc = 0;
        model_ir = '0;
        do_fetch(0, '0, 1, 0, 0, '0, 0, '0);

        // randomized fetches against the transaction model
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0) idle_branch(PC_W'($urandom));
            lat = ($urandom_range(0, 7) == 0) ? TIMEOUT : int'($urandom_range(0, 4));
            lastc = (lat >= TIMEOUT) ? TIMEOUT : lat + 2;
            c1 = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, lastc)) : 0;
            c2 = (c1 > 0 && c1 < lastc && $urandom_range(0, 1) == 1) ?
                 int'($urandom_range(c1 + 1, lastc)) : 0;
            wb = ($urandom_range(0, 3) == 0);
            do_fetch(wb, PC_W'($urandom), lat, 1'($urandom), c1, PC_W'($urandom),
                     c2, PC_W'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
